// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch stage: PC, next-PC select, IF/ID register, fault and fetch count
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_ADDRESS = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  input  logic                  Branch_Taken_i,
  input  logic [DATA_WIDTH-1:0] Branch_Target_i,
  input  logic                  Jump_i,
  input  logic [DATA_WIDTH-1:0] Jump_Target_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
  output logic [DATA_WIDTH-1:0] IFID_PC_Plus_4_o,
  output logic                  IFID_Valid_o,
  output logic                  Fetch_Fault_o,
  output logic [DATA_WIDTH-1:0] Fetch_Count_o
);

  typedef enum logic {RUN, FAULT} state_t;

  // One extra bit so a text segment reaching the top of the address space still compares correctly.
  localparam logic [DATA_WIDTH:0] SPAN = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_plus_4;
  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] offset;
  logic                  redirect;
  logic                  pc_advance;
  logic                  legal;

  assign pc_plus_4  = PC_o + DATA_WIDTH'(4);
  assign next_pc    = Jump_i ? Jump_Target_i : (Branch_Taken_i ? Branch_Target_i : pc_plus_4);
  assign offset     = next_pc - RESET_ADDRESS;
  assign legal      = (next_pc[1:0] == 2'b00) && (next_pc >= RESET_ADDRESS) && ({1'b0, offset} < SPAN);
  assign redirect   = Jump_i | Branch_Taken_i;
  assign pc_advance = redirect | ~Stall_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= RUN;
      PC_o               <= RESET_ADDRESS;
      IFID_Instruction_o <= '0;
      IFID_PC_Plus_4_o   <= '0;
      IFID_Valid_o       <= 1'b0;
      Fetch_Fault_o      <= 1'b0;
      Fetch_Count_o      <= '0;
    end else begin
      case (state)
        RUN: begin
          // A redirect moves the PC even while stalled; an illegal target freezes it and faults.
          if (pc_advance) begin
            if (legal) begin
              PC_o <= next_pc;
            end else begin
              state         <= FAULT;
              Fetch_Fault_o <= 1'b1;
            end
          end
          if (Flush_i) begin
            IFID_Instruction_o <= '0;
            IFID_PC_Plus_4_o   <= '0;
            IFID_Valid_o       <= 1'b0;
          end else if (!Stall_i) begin
            IFID_Instruction_o <= Instruction_i;
            IFID_PC_Plus_4_o   <= pc_plus_4;
            IFID_Valid_o       <= 1'b1;
            Fetch_Count_o      <= Fetch_Count_o + DATA_WIDTH'(1);
          end
        end
        FAULT: begin
          IFID_Instruction_o <= '0;
          IFID_PC_Plus_4_o   <= '0;
          IFID_Valid_o       <= 1'b0;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule
